// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage. Issues one SRAM read per cycle when
//                the stage can advance, holds the fetched word in a one-entry
//                skid buffer while the pre-decode stage stalls, and lets a
//                taken branch cancel the instruction currently in IF.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic [32:0] br_bus,
    input  logic        IPD_allow_in,
    output logic        IF_to_IPD_valid,
    output logic [63:0] IF_to_IPD_bus
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_PC_AT_RST  = RESET_PC - c_PC_STEP;

    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_inst_buf;
    logic        r_inst_buf_valid;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_if_ready_go;
    logic        w_if_allow_in;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_next_pc;
    logic        w_fetch_go;
    logic        w_skid_load;
    logic [31:0] w_inst;

    assign w_br_taken    = br_bus[32];
    assign w_br_target   = br_bus[31:0];

    // The stage never needs extra cycles, so it can always hand over.
    assign w_if_ready_go = 1'b1;
    assign w_if_allow_in = ~r_if_valid | (w_if_ready_go & IPD_allow_in);

    // Sequential address wraps naturally at 2^32.
    assign w_pc_plus_4   = r_pc + c_PC_STEP;
    assign w_next_pc     = w_br_taken ? w_br_target : w_pc_plus_4;

    // A taken branch forces a fetch even while downstream is stalled.
    assign w_fetch_go    = ~reset & (w_if_allow_in | w_br_taken);

    assign inst_sram_en   = w_fetch_go;
    assign inst_sram_addr = w_next_pc;

    // SRAM data is only valid the cycle after the request, so the first
    // stalled cycle must grab it before it disappears.
    assign w_skid_load = r_if_valid & ~IPD_allow_in & ~r_inst_buf_valid & ~w_br_taken;

    assign w_inst          = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;
    assign IF_to_IPD_valid = r_if_valid & w_if_ready_go & ~w_br_taken;
    assign IF_to_IPD_bus   = {w_pc_plus_4, w_inst};

    // PC and valid advance on every issued fetch and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= c_PC_AT_RST;
            r_if_valid <= 1'b0;
        end else if (w_fetch_go) begin
            r_pc       <= w_next_pc;
            r_if_valid <= 1'b1;
        end
    end

    // Skid buffer: filled once per stall, emptied whenever a new fetch goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_buf_valid <= 1'b0;
            r_inst_buf       <= 32'd0;
        end else if (w_fetch_go) begin
            r_inst_buf_valid <= 1'b0;
        end else if (w_skid_load) begin
            r_inst_buf_valid <= 1'b1;
            r_inst_buf       <= inst_sram_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. A program-order model
//                (expected address stream, redirected by taken branches and
//                restarted by reset) feeds a scoreboard queue; a monitor pops
//                and compares every handshake with the pre-decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_RESET_PC = 32'h1C000000;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [32:0] br_bus;
    logic        IPD_allow_in;
    logic        IF_to_IPD_valid;
    logic [63:0] IF_to_IPD_bus;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] r_last;

    if_stage #(.RESET_PC(c_RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .br_bus          (br_bus),
        .IPD_allow_in    (IPD_allow_in),
        .IF_to_IPD_valid (IF_to_IPD_valid),
        .IF_to_IPD_bus   (IF_to_IPD_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // SRAM: one-cycle read latency, random junk when no request was made.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_fn(inst_sram_addr);
        else              inst_sram_rdata <= $urandom();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order restarts at the reset vector.
    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(c_RESET_PC);
        r_last = c_RESET_PC;
    endtask

    // Advance one cycle; inputs change just after the edge. The next sequential
    // instruction becomes expected once the previous one has been delivered.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            r_last = r_last + 32'd4;
            exp_q.push_back(r_last);
        end
    endtask

    // Drive downstream readiness and the branch bus; a taken branch cancels
    // whatever was expected next and redirects program order.
    task automatic drive(input logic allow, input logic br, input logic [31:0] tgt);
        IPD_allow_in = allow;
        br_bus       = {br, tgt};
        if (br) begin
            exp_q.delete();
            exp_q.push_back(tgt);
            r_last = tgt;
        end
    endtask

    // Monitor: every accepted transfer must be the next instruction in program order.
    always @(negedge clk) begin
        if (!reset && IF_to_IPD_valid && IPD_allow_in) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", {32'd0, IF_to_IPD_bus[63:32]}, 64'd0);
            end else begin
                logic [31:0] h;
                h = exp_q.pop_front();
                check("deliv_pc_plus_4", {32'd0, IF_to_IPD_bus[63:32]}, {32'd0, h + 32'd4});
                check("deliv_inst",      {32'd0, IF_to_IPD_bus[31:0]},  {32'd0, mem_fn(h)});
            end
        end
    end

    initial begin
        reset = 1'b1;
        IPD_allow_in = 1'b1;
        br_bus = 33'd0;
        model_reset();
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_sram_en", {63'd0, inst_sram_en}, 64'd0);
        check("rst_valid",   {63'd0, IF_to_IPD_valid}, 64'd0);

        // Release reset: first fetch at the reset vector
        tick(); reset = 1'b0; drive(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("first_en",   {63'd0, inst_sram_en}, 64'd1);
        check("first_addr", {32'd0, inst_sram_addr}, {32'd0, c_RESET_PC});
        check("first_valid",{63'd0, IF_to_IPD_valid}, 64'd0);
        tick();
        @(negedge clk);
        check("second_valid", {63'd0, IF_to_IPD_valid}, 64'd1);
        check("second_pc4",   {32'd0, IF_to_IPD_bus[63:32]}, {32'd0, c_RESET_PC + 32'd4});
        check("second_addr",  {32'd0, inst_sram_addr}, {32'd0, c_RESET_PC + 32'd4});
        tick();
        @(negedge clk);
        check("third_addr",   {32'd0, inst_sram_addr}, {32'd0, c_RESET_PC + 32'd8});

        // Three-cycle stall while SRAM output turns to junk
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b0, 1'b0, 32'd0);
            @(negedge clk);
            check("stall_en",    {63'd0, inst_sram_en}, 64'd0);
            check("stall_valid", {63'd0, IF_to_IPD_valid}, 64'd1);
            check("stall_pc4",   {32'd0, IF_to_IPD_bus[63:32]}, {32'd0, exp_q[0] + 32'd4});
            check("stall_inst",  {32'd0, IF_to_IPD_bus[31:0]},  {32'd0, mem_fn(exp_q[0])});
        end
        tick(); drive(1'b1, 1'b0, 32'd0);
        tick();

        // Taken branch while IF holds a live instruction
        tick(); drive(1'b1, 1'b1, 32'h1C000100);
        @(negedge clk);
        check("br_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
        check("br_en",    {63'd0, inst_sram_en}, 64'd1);
        check("br_addr",  {32'd0, inst_sram_addr}, 64'h1C000100);
        tick(); drive(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("br_next_pc4", {32'd0, IF_to_IPD_bus[63:32]}, 64'h1C000104);

        // Branch during a stall with the skid buffer full
        tick(); drive(1'b0, 1'b0, 32'd0);
        tick();
        tick(); drive(1'b0, 1'b1, 32'h1C000200);
        @(negedge clk);
        check("brstall_en",    {63'd0, inst_sram_en}, 64'd1);
        check("brstall_addr",  {32'd0, inst_sram_addr}, 64'h1C000200);
        check("brstall_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
        tick(); drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("brstall_pc4",  {32'd0, IF_to_IPD_bus[63:32]}, 64'h1C000204);
        check("brstall_inst", {32'd0, IF_to_IPD_bus[31:0]}, {32'd0, mem_fn(32'h1C000200)});
        tick(); drive(1'b1, 1'b0, 32'd0);

        // Address wrap at the top of the space
        tick(); drive(1'b1, 1'b1, 32'hFFFFFFFC);
        tick(); drive(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("wrap_pc4",  {32'd0, IF_to_IPD_bus[63:32]}, 64'd0);
        check("wrap_addr", {32'd0, inst_sram_addr}, 64'd0);
        tick();

        // Reset asserted in the middle of a stall
        tick(); drive(1'b0, 1'b0, 32'd0);
        tick();
        tick(); reset = 1'b1; model_reset();
        tick();
        @(negedge clk);
        check("midrst_en",    {63'd0, inst_sram_en}, 64'd0);
        check("midrst_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
        tick(); reset = 1'b0; drive(1'b1, 1'b0, 32'd0);
        @(negedge clk);
        check("restart_en",   {63'd0, inst_sram_en}, 64'd1);
        check("restart_addr", {32'd0, inst_sram_addr}, {32'd0, c_RESET_PC});
        tick();
        @(negedge clk);
        check("restart_valid", {63'd0, IF_to_IPD_valid}, 64'd1);
        check("restart_pc4",   {32'd0, IF_to_IPD_bus[63:32]}, {32'd0, c_RESET_PC + 32'd4});

        // Random traffic: stalls, branches (some to the wrap point), rare resets
        for (int i = 0; i < 3000; i++) begin
            logic        allow;
            logic        br;
            logic [31:0] tgt;
            tick();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                reset = 1'b1;
                model_reset();
                drive(1'b1, 1'b0, 32'd0);
                continue;
            end
            allow = ($urandom_range(0, 99) < 65);
            br    = ($urandom_range(0, 99) < 10);
            tgt   = $urandom();
            tgt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFFFFF8;
            drive(allow, br, tgt);
        end
        tick(); drive(1'b1, 1'b0, 32'd0);
        repeat (3) tick();

        check("enough_deliveries", {63'd0, (n_deliv > 1000)}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h1C000000, giving the address of the first instruction fetched after reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port inst_sram_en, output, 1 bit, the instruction SRAM read enable.
REQ-005 The module SHALL have port inst_sram_addr, output, 32 bits, the instruction SRAM read address.
REQ-006 The module SHALL have port inst_sram_rdata, input, 32 bits, the read data, valid exactly one cycle after an enabled request.
REQ-007 The module SHALL have port br_bus, input, 33 bits, {br_taken[32], br_target[31:0]} from the ID stage.
REQ-008 The module SHALL have port IPD_allow_in, input, 1 bit, meaning the downstream pre-decode stage accepts data this cycle.
REQ-009 The module SHALL have port IF_to_IPD_valid, output, 1 bit, meaning IF_to_IPD_bus holds a live instruction.
REQ-010 The module SHALL have port IF_to_IPD_bus, output, 64 bits, {PC_plus_4[63:32], inst[31:0]}.

Function
REQ-011 The block SHALL hold pc_reg (32 bits), IF_valid (1 bit), inst_buf (32 bits) and inst_buf_valid (1 bit).
REQ-012 IF_ready_go SHALL be constant 1.
REQ-013 IF_allow_in SHALL equal ~IF_valid | IPD_allow_in.
REQ-014 next_pc SHALL equal br_target when br_taken=1, else pc_reg+4 modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-015 A fetch SHALL be issued when fetch_go = ~reset & (IF_allow_in | br_taken).
REQ-016 inst_sram_en SHALL equal fetch_go.
REQ-017 inst_sram_addr SHALL equal next_pc.
REQ-018 On fetch_go, pc_reg SHALL load next_pc and IF_valid SHALL load 1.
REQ-019 Without fetch_go, pc_reg and IF_valid SHALL hold.
REQ-020 IF_to_IPD_valid SHALL equal IF_valid & ~br_taken, so a taken branch cancels the instruction currently in IF in the same cycle.
REQ-021 PC_plus_4 on the bus SHALL equal pc_reg+4, with the same wrap rule as REQ-014.
REQ-022 inst on the bus SHALL equal inst_buf when inst_buf_valid=1, else inst_sram_rdata.
REQ-023 Skid capture: when IF_valid=1, IPD_allow_in=0, inst_buf_valid=0 and br_taken=0, inst_buf SHALL load inst_sram_rdata and inst_buf_valid SHALL set.
REQ-024 inst_buf_valid SHALL clear on any cycle with fetch_go=1.
REQ-025 While IF is stalled with inst_buf_valid=1, inst_buf SHALL not be overwritten regardless of inst_sram_rdata.
REQ-026 Simultaneous br_taken and IPD_allow_in=0: br_taken SHALL win; the held instruction is dropped, the buffer cleared, and br_target fetched.
REQ-027 Each fetched address SHALL be delivered to IPD exactly once unless cancelled by br_taken; no instruction is duplicated or skipped across a stall of any length.

Reset
REQ-028 While reset=1: pc_reg SHALL be RESET_PC-4, IF_valid=0, inst_buf_valid=0, inst_sram_en=0, IF_to_IPD_valid=0.
REQ-029 In the first cycle after reset deasserts, inst_sram_en SHALL be 1 with inst_sram_addr=RESET_PC.
REQ-030 In the second cycle after reset deasserts, IF_to_IPD_valid SHALL be 1 and PC_plus_4 SHALL equal RESET_PC+4.
REQ-031 Reset asserted mid-stall or mid-branch SHALL discard all in-flight state on the next clock edge.

Verification
REQ-032 Reset then IPD_allow_in=1 held -> addresses 1C000000, 1C000004, 1C000008 on consecutive cycles; bus PC_plus_4 1C000004, 1C000008, ... one cycle later.
REQ-033 Stall IPD_allow_in=0 for 3 cycles while SRAM rdata changes to junk -> inst held equal to the pre-stall data, inst_sram_en=0, pc_reg unchanged; release -> next address fetched, no repeat or skip.
REQ-034 br_taken=1, target 1C000100, while IF_valid=1 -> IF_to_IPD_valid=0 that cycle, addr=1C000100; next cycle PC_plus_4=1C000104.
REQ-035 br_taken=1 with IPD_allow_in=0 and inst_buf_valid=1 -> fetch of target issued, buffer cleared, stale instruction never presented valid.
REQ-036 br_target=FFFFFFFC then sequential flow -> PC_plus_4=00000000, next fetch address 00000000.
REQ-037 reset asserted during a stall -> following cycle all outputs at REQ-028 values; restart matches REQ-029 and REQ-030.
